// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe
//   Three-stage pipelined Barrett reducer: dout = din mod Q for any 2K-bit din.
//   Accepts one operand per clock. Each operand carries a sideband tag that is
//   returned with its result. A stall freezes all three stages together.
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake for din/in_tag
//   din [2K-1:0]          operand
//   in_tag [TAG_W-1:0]    sideband tag
//   out_valid/out_ready   output handshake for dout/out_tag
//   dout [K-1:0]          din mod Q
//   out_tag [TAG_W-1:0]   tag of the operand that produced dout
//   busy                  any stage holds a valid operand
module barrett_reduce_pipe #(
    parameter int unsigned Q     = 2351,
    parameter int unsigned K     = 12,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*K-1:0]   din,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     dout,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // 2^(K-1) < Q < 2^K bounds MU below 2^(K+1), so K+1 bits hold it exactly.
    localparam logic [K:0]   MU  = (K+1)'((64'd1 << (2*K)) / 64'(Q));
    localparam logic [K+1:0] Q1R = (K+2)'(Q);
    localparam logic [K+1:0] Q2R = (K+2)'(2*Q);

    // Stage 1
    logic             s1_v_q, s1_v_d;
    logic [2*K-1:0]   x1_q, x1_d;
    logic [K:0]       q1_q, q1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;
    // Stage 2
    logic             s2_v_q, s2_v_d;
    logic [2*K-1:0]   x2_q, x2_d;
    logic [K:0]       t2_q, t2_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;
    // Stage 3 (output register)
    logic             s3_v_q, s3_v_d;
    logic [K-1:0]     dout_q, dout_d;
    logic [TAG_W-1:0] tag3_q, tag3_d;

    logic             stall;
    logic [2*K+1:0]   q2;
    logic [2*K:0]     tq;
    logic [2*K:0]     diff;
    logic [K+1:0]     r;
    logic [K+1:0]     red;
    logic             unused_bits;

    assign stall     = s3_v_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = s3_v_q;
    assign dout      = dout_q;
    assign out_tag   = tag3_q;
    assign busy      = s1_v_q || s2_v_q || s3_v_q;

    // Full-width arithmetic; only the final remainder is taken mod 2^(K+2),
    // which is exact because the true remainder is below 3Q < 2^(K+2).
    always_comb begin
        q2   = (2*K+2)'(q1_q) * (2*K+2)'(MU);
        tq   = (2*K+1)'(t2_q) * (2*K+1)'(Q);
        diff = (2*K+1)'(x2_q) - tq;
        r    = diff[K+1:0];
        if (r >= Q2R) begin
            red = r - Q2R;
        end else if (r >= Q1R) begin
            red = r - Q1R;
        end else begin
            red = r;
        end
    end

    // Low product bits drop out of the shifts; high bits of red/diff are zero.
    assign unused_bits = ^{q2[K:0], diff[2*K:K+2], red[K+1:K]};

    always_comb begin
        s1_v_d = s1_v_q;  x1_d = x1_q;  q1_d = q1_q;  tag1_d = tag1_q;
        s2_v_d = s2_v_q;  x2_d = x2_q;  t2_d = t2_q;  tag2_d = tag2_q;
        s3_v_d = s3_v_q;  dout_d = dout_q;  tag3_d = tag3_q;
        if (!stall) begin
            // in_ready is 1 here, so in_valid alone marks an accept.
            s1_v_d = in_valid;
            x1_d   = din;
            q1_d   = din[2*K-1:K-1];
            tag1_d = in_tag;
            s2_v_d = s1_v_q;
            x2_d   = x1_q;
            t2_d   = q2[2*K+1:K+1];
            tag2_d = tag1_q;
            s3_v_d = s2_v_q;
            dout_d = red[K-1:0];
            tag3_d = tag2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;  x1_q <= '0;  q1_q <= '0;  tag1_q <= '0;
            s2_v_q <= 1'b0;  x2_q <= '0;  t2_q <= '0;  tag2_q <= '0;
            s3_v_q <= 1'b0;  dout_q <= '0;  tag3_q <= '0;
        end else begin
            s1_v_q <= s1_v_d;  x1_q <= x1_d;  q1_q <= q1_d;  tag1_q <= tag1_d;
            s2_v_q <= s2_v_d;  x2_q <= x2_d;  t2_q <= t2_d;  tag2_q <= tag2_d;
            s3_v_q <= s3_v_d;  dout_q <= dout_d;  tag3_q <= tag3_d;
        end
    end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Testbench for barrett_reduce_pipe: default instance (Q=2351,K=12) plus
// Q=3329/K=12 and Q=7681/K=13 instances for corner vectors.
module tb_barrett_reduce_pipe;

    localparam int unsigned QA = 2351;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_iv, a_ir, a_ov, a_or, a_busy;
    logic [23:0] a_din;
    logic [3:0]  a_itag, a_otag;
    logic [11:0] a_dout;

    logic        b_iv, b_ir, b_ov, b_or, b_busy;
    logic [23:0] b_din;
    logic [3:0]  b_itag, b_otag;
    logic [11:0] b_dout;

    logic        c_iv, c_ir, c_ov, c_or, c_busy;
    logic [25:0] c_din;
    logic [3:0]  c_itag, c_otag;
    logic [12:0] c_dout;

    barrett_reduce_pipe #(.Q(2351), .K(12), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .din(a_din),
        .in_tag(a_itag), .out_valid(a_ov), .out_ready(a_or), .dout(a_dout),
        .out_tag(a_otag), .busy(a_busy));

    barrett_reduce_pipe #(.Q(3329), .K(12), .TAG_W(4)) u_q3329 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .din(b_din),
        .in_tag(b_itag), .out_valid(b_ov), .out_ready(b_or), .dout(b_dout),
        .out_tag(b_otag), .busy(b_busy));

    barrett_reduce_pipe #(.Q(7681), .K(13), .TAG_W(4)) u_q7681 (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .din(c_din),
        .in_tag(c_itag), .out_valid(c_ov), .out_ready(c_or), .dout(c_dout),
        .out_tag(c_otag), .busy(c_busy));

    int n_assert = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    logic [15:0] sb[$];   // {tag, expected remainder}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock on the default instance; entered and left 1 time unit after posedge.
    task automatic cycle(input logic iv, input logic [23:0] d, input logic [3:0] tg,
                         input logic ordy, output logic acc);
        a_iv = iv; a_din = d; a_itag = tg; a_or = ordy;
        #1;
        check("in_ready", a_ir, !(a_ov && !ordy));
        if (a_ov) begin
            if (sb.size() == 0) begin
                check("spurious_out", a_ov, 1'b0);
            end else begin
                check("dout", a_dout, sb[0][11:0]);
                check("out_tag", a_otag, sb[0][15:12]);
                check("dout_lt_q", a_dout < QA, 1'b1);
                if (ordy) begin
                    void'(sb.pop_front());
                    n_xfer++;
                end
            end
        end
        acc = iv && a_ir;
        if (acc) sb.push_back({tg, 12'(d % QA)});
        @(posedge clk); #1;
    endtask

    task automatic drain();
        logic acc;
        int g = 0;
        while (sb.size() > 0 && g < 64) begin
            cycle(1'b0, '0, '0, 1'b1, acc);
            g++;
        end
        check("drain_empty", sb.size(), 0);
        check("drain_busy", a_busy, 1'b0);
    endtask

    function automatic logic sel_ov(input int w);
        case (w)
            0: return a_ov;
            1: return b_ov;
            default: return c_ov;
        endcase
    endfunction

    // Single operand on a chosen instance; checks 3-cycle latency, value and tag.
    task automatic single(input int w, input logic [25:0] d, input logic [3:0] tg,
                          input logic [12:0] er);
        int cyc;
        logic [12:0] od;
        logic [3:0]  ot;
        case (w)
            0: begin a_iv = 1'b1; a_din = d[23:0]; a_itag = tg; a_or = 1'b1; end
            1: begin b_iv = 1'b1; b_din = d[23:0]; b_itag = tg; b_or = 1'b1; end
            default: begin c_iv = 1'b1; c_din = d; c_itag = tg; c_or = 1'b1; end
        endcase
        #1;
        check("single_in_ready", (w == 0) ? a_ir : (w == 1) ? b_ir : c_ir, 1'b1);
        @(posedge clk); #1;
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
        cyc = 1;
        while (!sel_ov(w) && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        case (w)
            0: begin od = {1'b0, a_dout}; ot = a_otag; end
            1: begin od = {1'b0, b_dout}; ot = b_otag; end
            default: begin od = c_dout; ot = c_otag; end
        endcase
        check("latency", cyc, 3);
        check("corner_dout", od, er);
        check("corner_tag", ot, tg);
        @(posedge clk); #1;
    endtask

    initial begin
        logic acc;
        int n_acc, sent, guard, idx;
        logic pend;
        logic [23:0] pd;
        logic [3:0]  pt;
        logic [23:0] hold_vec[4];

        rst_n = 1'b0;
        a_iv = 0; a_din = '0; a_itag = '0; a_or = 1'b1;
        b_iv = 0; b_din = '0; b_itag = '0; b_or = 1'b1;
        c_iv = 0; c_din = '0; c_itag = '0; c_or = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", a_ov, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_out_valid", a_ov, 1'b0);
        check("rel_in_ready", a_ir, 1'b1);
        check("rel_dout", a_dout, 12'd0);
        check("rel_out_tag", a_otag, 4'd0);
        check("rel_busy", a_busy, 1'b0);

        // Corners on Q=2351
        single(0, 26'd0,        4'd1, 13'd0);
        single(0, 26'd2351,     4'd2, 13'd0);
        single(0, 26'd2350,     4'd3, 13'd2350);
        single(0, 26'd16777215, 4'd4, 13'd479);
        single(0, 26'd5522500,  4'd5, 13'd1);
        single(0, 26'd4702,     4'd6, 13'd0);
        single(0, 26'd7052,     4'd7, 13'd2350);
        // Q=3329, K=12
        single(1, 26'd0,        4'd8, 13'd0);
        single(1, 26'd3329,     4'd9, 13'd0);
        single(1, 26'd3328,     4'd10, 13'd3328);
        single(1, 26'd16777215, 4'd11, 13'd2384);
        single(1, 26'd11075584, 4'd12, 13'd1);
        // Q=7681, K=13
        single(2, 26'd0,        4'd13, 13'd0);
        single(2, 26'd7681,     4'd14, 13'd0);
        single(2, 26'd7680,     4'd15, 13'd7680);
        single(2, 26'd67108863, 4'd1, 13'd7647);
        single(2, 26'd58982400, 4'd2, 13'd1);

        // Reset with three operands in flight
        cycle(1'b1, 24'd1000, 4'hA, 1'b1, acc);
        cycle(1'b1, 24'd2000, 4'hB, 1'b1, acc);
        cycle(1'b1, 24'd3000, 4'hC, 1'b1, acc);
        a_iv = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", a_ov, 1'b0);
        check("midrst_busy", a_busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        repeat (6) cycle(1'b0, '0, '0, 1'b1, acc);
        check("post_rst_busy", a_busy, 1'b0);

        // Back-to-back streaming
        n_acc = 0;
        n_xfer = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 24'($urandom), 4'($urandom), 1'b1, acc);
            if (acc) n_acc++;
        end
        drain();
        check("stream_accepts", n_acc, 300);
        check("stream_xfers", n_xfer, 300);

        // Backpressure: 8 cycles with out_ready low, then release
        hold_vec[0] = 24'd123456; hold_vec[1] = 24'd16777215;
        hold_vec[2] = 24'd2351;   hold_vec[3] = 24'd9999;
        idx = 0;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, hold_vec[idx], 4'(idx + 3), 1'b0, acc);
            if (acc) begin idx++; n_acc++; end
        end
        check("hold_accepts", n_acc, 3);
        check("hold_in_ready", a_ir, 1'b0);
        guard = 0;
        while (idx < 4 && guard < 16) begin
            cycle(1'b1, hold_vec[idx], 4'(idx + 3), 1'b1, acc);
            if (acc) idx++;
            guard++;
        end
        check("hold_all_sent", idx, 4);
        drain();

        // Random valid/ready
        sent = 0; guard = 0; pend = 1'b0; pd = '0; pt = '0;
        while (sent < 2000 && guard < 20000) begin
            if (!pend && $urandom_range(1) == 1) begin
                pend = 1'b1;
                pd = 24'($urandom);
                pt = 4'($urandom);
            end
            cycle(pend, pd, pt, 1'($urandom_range(1)), acc);
            if (acc) begin pend = 1'b0; sent++; end
            guard++;
        end
        check("random_sent", sent, 2000);
        drain();
        check("idle_busy_b", b_busy, 1'b0);
        check("idle_busy_c", c_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
